// File: rtl/c1541_pkg.sv
// Shared definitions for the 1541 track-buffer loader.
//   state_t      : loader FSM states
//   TRK_INVALID  : marker for "no track in buffer"
//   D64_*        : D64 speed-zone sector counts and zone start tracks
package c1541_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT
  } state_t;

  localparam logic [6:0]  TRK_INVALID    = 7'h7F;

  // Sectors per track in each of the four speed zones.
  localparam logic [31:0] D64_SPT_Z1     = 32'd21;
  localparam logic [31:0] D64_SPT_Z2     = 32'd19;
  localparam logic [31:0] D64_SPT_Z3     = 32'd18;
  localparam logic [31:0] D64_SPT_Z4     = 32'd17;

  // First track of zones 2..4 and the highest addressable track.
  localparam logic [31:0] D64_ZONE2_TRK  = 32'd18;
  localparam logic [31:0] D64_ZONE3_TRK  = 32'd25;
  localparam logic [31:0] D64_ZONE4_TRK  = 32'd31;
  localparam logic [31:0] D64_MAX_TRK    = 32'd42;

  // Sector index of the first sector of each zone (357, 490, 598).
  localparam logic [31:0] D64_ZONE2_BASE = (D64_ZONE2_TRK - 32'd1) * D64_SPT_Z1;
  localparam logic [31:0] D64_ZONE3_BASE = D64_ZONE2_BASE + (D64_ZONE3_TRK - D64_ZONE2_TRK) * D64_SPT_Z2;
  localparam logic [31:0] D64_ZONE4_BASE = D64_ZONE3_BASE + (D64_ZONE4_TRK - D64_ZONE3_TRK) * D64_SPT_Z3;

endpackage

// File: rtl/c1541_d64_offset.sv
// Combinational D64 track -> first-sector index.
//   i_t     : D64 track number 1..42
//   o_start : number of sectors in tracks 1..i_t-1
// The largest value (track 42) is 785, so the result needs 10 bits.
module c1541_d64_offset
  import c1541_pkg::*;
(
  input  logic [5:0] i_t,
  output logic [9:0] o_start
);

  logic [31:0] w_t;
  logic [31:0] w_sum;

  always_comb begin
    w_t = {26'd0, i_t};
    if (w_t < D64_ZONE2_TRK)
      w_sum = (w_t - 32'd1) * D64_SPT_Z1;
    else if (w_t < D64_ZONE3_TRK)
      w_sum = D64_ZONE2_BASE + (w_t - D64_ZONE2_TRK) * D64_SPT_Z2;
    else if (w_t < D64_ZONE4_TRK)
      w_sum = D64_ZONE3_BASE + (w_t - D64_ZONE3_TRK) * D64_SPT_Z3;
    else
      w_sum = D64_ZONE4_BASE + (w_t - D64_ZONE4_TRK) * D64_SPT_Z4;
    o_start = w_sum[9:0];
  end

endmodule

// File: rtl/c1541_track_loader.sv
// Track-buffer loader (clk_sys side of the 1541). Keeps the track buffer in
// step with the head position by issuing SD block reads, and writes a
// modified track back on request.
//   clk, reset      : system clock, synchronous active-high reset
//   gcr_mode        : 1 = G64 image, 0 = D64 image
//   change          : img_mounted level, rising edge invalidates the buffer
//   track           : half-track from the drive clock domain
//   save_track      : toggle, each edge requests write-back of loaded track
//   sd_lba          : first block of the request
//   sd_blk_cnt      : blocks minus one
//   sd_rd / sd_wr   : SD read / write request, held until sd_ack
//   sd_ack          : SD controller acknowledge
//   busy            : buffer not (yet) valid for the current track
module c1541_track_loader
  import c1541_pkg::*;
#(
  parameter int G64_BLKS = 16,
  parameter int D64_BLKS = 11
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        gcr_mode,
  input  logic        change,
  input  logic [6:0]  track,
  input  logic        save_track,
  output logic [31:0] sd_lba,
  output logic [5:0]  sd_blk_cnt,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic        busy
);

  logic [6:0]  r_trk_m, r_trk_s, r_trk_d, r_track_s;
  logic        r_save_m, r_save_s, r_save_d;
  logic        r_chg_m, r_chg_s, r_chg_d;

  state_t      r_state, w_state_nxt;
  logic [6:0]  r_loaded, w_loaded_nxt;
  logic [6:0]  r_target, w_target_nxt;
  logic        r_save_pend, w_save_pend_nxt;
  logic        r_chg_pend, w_chg_pend_nxt;
  logic        r_sd_rd, r_sd_wr, r_busy, w_busy_nxt;
  logic [31:0] r_sd_lba;
  logic [5:0]  r_sd_cnt;
  logic        w_req_load;

  logic        w_save_edge, w_chg_edge, w_ld_valid, w_do_save, w_do_read;
  logic [6:0]  w_idx, w_t7;
  logic [5:0]  w_t;
  logic [9:0]  w_start;
  logic [31:0] w_lba;
  logic [5:0]  w_cnt;

  // Synchronisers. The track chain resets to "invalid" so no read is issued
  // before the real head position has come through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_trk_m   <= TRK_INVALID;
      r_trk_s   <= TRK_INVALID;
      r_trk_d   <= TRK_INVALID;
      r_track_s <= TRK_INVALID;
      r_save_m  <= 1'b0;
      r_save_s  <= 1'b0;
      r_save_d  <= 1'b0;
      r_chg_m   <= 1'b0;
      r_chg_s   <= 1'b0;
      r_chg_d   <= 1'b0;
    end else begin
      r_trk_m  <= track;
      r_trk_s  <= r_trk_m;
      r_trk_d  <= r_trk_s;
      // Accept the track only once it has held for two cycles, so a
      // multi-bit change caught mid-transition is never used.
      if (r_trk_s == r_trk_d)
        r_track_s <= r_trk_d;
      r_save_m <= save_track;
      r_save_s <= r_save_m;
      r_save_d <= r_save_s;
      r_chg_m  <= change;
      r_chg_s  <= r_chg_m;
      r_chg_d  <= r_chg_s;
    end
  end

  assign w_save_edge = r_save_s ^ r_save_d;
  assign w_chg_edge  = r_chg_s & ~r_chg_d;
  assign w_ld_valid  = (r_loaded != TRK_INVALID);
  assign w_do_save   = r_save_pend & w_ld_valid;
  assign w_do_read   = (r_track_s != r_loaded) && (r_track_s != TRK_INVALID);

  // Address of the request about to be issued: write-back uses the loaded
  // track, a read uses the current head position.
  assign w_idx = w_do_save ? r_loaded : r_track_s;
  assign w_t7  = {1'b0, w_idx[6:1]} + 7'd1;
  assign w_t   = (w_t7 > 7'(D64_MAX_TRK)) ? 6'(D64_MAX_TRK) : w_t7[5:0];

  c1541_d64_offset u_d64_offset (
    .i_t     (w_t),
    .o_start (w_start)
  );

  assign w_lba = gcr_mode ? ({25'd0, w_idx} * 32'(G64_BLKS))
                          : ({22'd0, w_start} >> 1);
  assign w_cnt = gcr_mode ? 6'(G64_BLKS - 1) : 6'(D64_BLKS - 1);

  always_comb begin
    w_state_nxt     = r_state;
    w_loaded_nxt    = r_loaded;
    w_target_nxt    = r_target;
    w_save_pend_nxt = r_save_pend | (w_save_edge & w_ld_valid);
    w_chg_pend_nxt  = r_chg_pend;
    w_req_load      = 1'b0;
    w_busy_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_chg_edge) begin
          w_loaded_nxt    = TRK_INVALID;
          w_save_pend_nxt = 1'b0;
        end else if (!sd_ack) begin
          // Holding off while sd_ack is high covers an ack left over from a
          // transfer cut short by reset.
          if (w_do_save) begin
            w_state_nxt     = ST_WR_REQ;
            w_save_pend_nxt = 1'b0;
            w_req_load      = 1'b1;
          end else if (w_do_read) begin
            w_state_nxt  = ST_RD_REQ;
            w_target_nxt = r_track_s;
            w_req_load   = 1'b1;
          end
        end
      end
      ST_WR_REQ:  if (sd_ack)  w_state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: if (!sd_ack) w_state_nxt = ST_IDLE;
      ST_RD_REQ:  if (sd_ack)  w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (!sd_ack) begin
          w_state_nxt  = ST_IDLE;
          w_loaded_nxt = r_target;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A mount change during a transfer is deferred until the handshake is
    // over; it then forces a fresh read and drops any pending save.
    if (r_state != ST_IDLE) begin
      if (w_chg_edge)
        w_chg_pend_nxt = 1'b1;
      if ((w_state_nxt == ST_IDLE) && (r_chg_pend || w_chg_edge)) begin
        w_loaded_nxt    = TRK_INVALID;
        w_save_pend_nxt = 1'b0;
        w_chg_pend_nxt  = 1'b0;
      end
    end

    // Busy also covers an idle cycle with work still pending, so the GCR
    // stage never sees a stale buffer between requests.
    w_busy_nxt = (w_state_nxt != ST_IDLE)
               | (w_save_pend_nxt & (w_loaded_nxt != TRK_INVALID))
               | ((r_track_s != w_loaded_nxt) & (r_track_s != TRK_INVALID));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_loaded    <= TRK_INVALID;
      r_target    <= TRK_INVALID;
      r_save_pend <= 1'b0;
      r_chg_pend  <= 1'b0;
      r_sd_rd     <= 1'b0;
      r_sd_wr     <= 1'b0;
      r_busy      <= 1'b0;
      r_sd_lba    <= 32'd0;
      r_sd_cnt    <= 6'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_loaded    <= w_loaded_nxt;
      r_target    <= w_target_nxt;
      r_save_pend <= w_save_pend_nxt;
      r_chg_pend  <= w_chg_pend_nxt;
      r_sd_rd     <= (w_state_nxt == ST_RD_REQ);
      r_sd_wr     <= (w_state_nxt == ST_WR_REQ);
      r_busy      <= w_busy_nxt;
      if (w_req_load) begin
        r_sd_lba <= w_lba;
        r_sd_cnt <= w_cnt;
      end
    end
  end

  assign sd_rd      = r_sd_rd;
  assign sd_wr      = r_sd_wr;
  assign busy       = r_busy;
  assign sd_lba     = r_sd_lba;
  assign sd_blk_cnt = r_sd_cnt;

endmodule

// File: tb/tb_c1541_track_loader.sv
module tb_c1541_track_loader;

  localparam int G64B = 16;

  logic        clk = 1'b0;
  logic        rst_stim, rst_resp;
  logic        reset;
  logic        gcr_mode, change, save_track, sd_ack;
  logic [6:0]  track;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd, sd_wr, busy;

  assign reset = rst_stim | rst_resp;

  always #5 clk = ~clk;

  c1541_track_loader #(.G64_BLKS(16), .D64_BLKS(11)) dut (
    .clk        (clk),
    .reset      (reset),
    .gcr_mode   (gcr_mode),
    .change     (change),
    .track      (track),
    .save_track (save_track),
    .sd_lba     (sd_lba),
    .sd_blk_cnt (sd_blk_cnt),
    .sd_rd      (sd_rd),
    .sd_wr      (sd_wr),
    .sd_ack     (sd_ack),
    .busy       (busy)
  );

  typedef struct {
    bit          wr;
    int unsigned lba;
    int unsigned cnt;
  } req_t;

  req_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_loaded = -1;
  int   resp_dly  = 3;
  int   resp_hold = 17;
  bit   rst_on_ack = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: sectors per track by zone, summed track by track.
  function automatic int unsigned ref_lba(input bit g, input int trk);
    int t;
    int unsigned s;
    s = 0;
    if (g) return trk * G64B;
    t = trk / 2 + 1;
    if (t > 42) t = 42;
    for (int i = 1; i < t; i++)
      s += (i <= 17) ? 21 : (i <= 24) ? 19 : (i <= 30) ? 18 : 17;
    return s / 2;
  endfunction

  function automatic void push(input bit wr, input int trk);
    req_t e;
    e.wr  = wr;
    e.lba = ref_lba(gcr_mode, trk);
    e.cnt = gcr_mode ? 15 : 10;
    exp_q.push_back(e);
  endfunction

  task automatic wait_quiet(input string name);
    int q = 0;
    int n = 0;
    while (q < 16 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (!busy && !sd_rd && !sd_wr && !sd_ack) q++;
      else q = 0;
    end
    chk({name, "_quiet"}, (n < 3000), 1);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic wait_req(input bit wr, input string name);
    int n = 0;
    while (!(wr ? sd_wr : sd_rd) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_seen"}, (n < 200), 1);
  endtask

  // SD controller model: ack a few cycles after a request, hold, release.
  initial begin
    sd_ack   = 1'b0;
    rst_resp = 1'b0;
    forever begin
      @(negedge clk);
      if ((sd_rd || sd_wr) && !sd_ack) begin
        repeat (resp_dly) @(negedge clk);
        sd_ack   = 1'b1;
        rst_resp = rst_on_ack;
        @(negedge clk);
        rst_resp = 1'b0;
        repeat (resp_hold - 1) @(negedge clk);
        sd_ack = 1'b0;
      end
    end
  end

  // Monitor: pop the expected request when one appears, then watch the
  // transfer until sd_ack falls.
  initial begin
    bit          in_x, seen, bad, prev;
    logic [31:0] cl;
    logic [5:0]  cc;
    req_t        e;
    in_x = 0; seen = 0; bad = 0; prev = 0; cl = '0; cc = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        in_x = 0;
        prev = 0;
      end else begin
        if ((sd_rd || sd_wr) && !prev && !in_x) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req rd=%0b wr=%0b lba=%0d required=none", sd_rd, sd_wr, sd_lba);
          end else begin
            e = exp_q.pop_front();
            chk("req_wr", sd_wr, e.wr);
            chk("req_rd", sd_rd, !e.wr);
            chk("req_lba", sd_lba, e.lba);
            chk("req_cnt", sd_blk_cnt, e.cnt);
            chk("ack_low_at_req", sd_ack, 0);
          end
          in_x = 1; seen = 0; bad = !busy; cl = sd_lba; cc = sd_blk_cnt;
        end else if (in_x) begin
          if (sd_ack) seen = 1;
          if (seen && !sd_ack) begin
            chk("xfer_stable_busy", bad, 0);
            in_x = 0;
          end else if (sd_lba != cl || sd_blk_cnt != cc || !busy || (sd_rd && sd_wr)) begin
            bad = 1;
          end
        end
        prev = sd_rd || sd_wr;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog checks=%0d required=finish", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int nt, r;
    bit sv;
    rst_stim = 1'b1; gcr_mode = 1'b0; change = 1'b1; track = 7'd34; save_track = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_cnt", sd_blk_cnt, 0);

    // D64 basic load: track 34 -> t=18 -> lba 178
    push(0, 34); m_loaded = 34;
    @(negedge clk); rst_stim = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_reset", busy, 0);
    wait_quiet("d64_load");

    // G64 load of half-track 35 -> lba 560, then remount reloads it
    @(negedge clk); change = 1'b0; gcr_mode = 1'b1; push(0, 35); m_loaded = 35; track = 7'd35;
    wait_quiet("g64_load");
    @(negedge clk); change = 1'b1; push(0, 35);
    wait_quiet("g64_remount");

    // Back to D64 with track 34 loaded
    @(negedge clk); change = 1'b0; gcr_mode = 1'b0; push(0, 34); m_loaded = 34; track = 7'd34;
    wait_quiet("d64_reload");
    @(negedge clk); change = 1'b1; push(0, 34);
    wait_quiet("d64_remount");

    // Write-back then read: save and new track on the same cycle
    push(1, 34); push(0, 36); m_loaded = 36;
    @(negedge clk); save_track = ~save_track; track = 7'd36;
    wait_quiet("wb_then_rd");

    // Track change while the read is in RD_WAIT
    push(0, 40);
    @(negedge clk); track = 7'd40;
    wait_req(0, "mid_rd_first");
    repeat (8) @(negedge clk);
    push(0, 50); track = 7'd50; m_loaded = 50;
    wait_quiet("mid_rd");

    // Mount change during WR_WAIT, then a save toggle that must be dropped
    push(1, 50); push(0, 50);
    @(negedge clk); save_track = ~save_track;
    wait_req(1, "mount_wr_first");
    repeat (7) @(negedge clk);
    change = 1'b0;
    repeat (2) @(negedge clk);
    change = 1'b1;
    repeat (2) @(negedge clk);
    save_track = ~save_track;
    wait_quiet("mount_in_wr");

    // Randomised traffic
    for (int it = 0; it < 24; it++) begin
      r         = $urandom_range(0, 9);
      resp_dly  = $urandom_range(1, 5);
      resp_hold = $urandom_range(2, 20);
      if (r < 6) begin
        nt = $urandom_range(0, 84);
        sv = 1'($urandom_range(0, 1));
        if (sv && m_loaded >= 0) push(1, m_loaded);
        if (nt != m_loaded) begin
          push(0, nt);
          m_loaded = nt;
        end
        @(negedge clk);
        track = 7'(nt);
        if (sv) save_track = ~save_track;
      end else if (r < 8) begin
        if (m_loaded >= 0) push(1, m_loaded);
        @(negedge clk); save_track = ~save_track;
      end else begin
        @(negedge clk); change = 1'b0;
        repeat (4) @(negedge clk);
        gcr_mode = 1'($urandom_range(0, 1));
        @(negedge clk); change = 1'b1;
        push(0, int'(track)); m_loaded = int'(track);
      end
      wait_quiet("rand");
    end

    // Reset while sd_rd and sd_ack are both high
    resp_dly = 3; resp_hold = 17;
    nt = (m_loaded + 7) % 85;
    push(0, nt);
    rst_on_ack = 1'b1;
    @(negedge clk); track = 7'(nt);
    begin
      int n = 0;
      while (!reset && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk("abort_reset_seen", (n < 200), 1);
    end
    chk("abort_sd_rd", sd_rd, 0);
    chk("abort_busy", busy, 0);
    rst_on_ack = 1'b0;
    push(0, nt); m_loaded = nt;
    wait_quiet("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
